// File: rtl/alu_serial.sv
// Digit-serial ALU: WIDTH-bit operands are processed DIGIT bits per clock, LSB digit first.
// One operation takes STEPS+1 edges from accept to result; the result holds until the next completion.
module alu_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 1,
  localparam int STEPS = WIDTH / DIGIT,
  localparam int CW = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             on,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  input  logic [2:0]       op,
  output logic [WIDTH:0]   out,
  output logic [CW-1:0]    count,
  output logic             busy,
  output logic             done,
  output logic             zero
);

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NAND = 3'b101;
  localparam logic [2:0] OP_NOR  = 3'b110;

  localparam logic [CW-1:0] LAST_COUNT = CW'(STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_reg, state_next;
  logic             load, step, last;

  logic [WIDTH-1:0] a_reg, b_reg, acc_reg;
  logic [2:0]       op_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;
  logic [WIDTH:0]   out_reg;
  logic             zero_reg;
  logic             done_reg;

  logic             is_sub, is_arith;
  logic [DIGIT:0]   cy;
  logic [DIGIT-1:0] bx;
  logic [DIGIT-1:0] res_digit;
  logic [WIDTH-1:0] acc_next;
  logic             final_msb;

  function automatic logic digit_bit(input logic [2:0] code, input logic a, input logic b,
                                     input logic c);
    case (code)
      OP_ADD:  return a ^ b ^ c;
      OP_SUB:  return a ^ ~b ^ c;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      OP_NOR:  return ~(a | b);
      default: return ~(a ^ b);
    endcase
  endfunction

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (on) state_next = RUN;
      RUN:     if (count_reg == LAST_COUNT) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM: control strobes
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    last = 1'b0;
    case (state_reg)
      IDLE: load = on;
      RUN: begin
        step = 1'b1;
        last = (count_reg == LAST_COUNT);
      end
      default: ;
    endcase
  end

  assign is_sub   = (op_reg == OP_SUB);
  assign is_arith = (op_reg[2:1] == 2'b00);
  assign cy[0]    = carry_reg;

  // One ripple-carry slice per digit bit; ~B for subtract.
  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
      assign bx[gi]        = b_reg[gi] ^ is_sub;
      assign cy[gi+1]      = (a_reg[gi] & bx[gi]) | (cy[gi] & (a_reg[gi] ^ bx[gi]));
      assign res_digit[gi] = digit_bit(op_reg, a_reg[gi], b_reg[gi], cy[gi]);
    end

    if (STEPS > 1) begin : g_acc_shift
      assign acc_next = {res_digit, acc_reg[WIDTH-1:DIGIT]};
    end else begin : g_acc_single
      assign acc_next = res_digit;
    end
  endgenerate

  // Subtract reports borrow, which is the inverted carry-out.
  assign final_msb = is_arith ? (cy[DIGIT] ^ is_sub) : 1'b0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      b_reg     <= '0;
      acc_reg   <= '0;
      op_reg    <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      out_reg   <= '0;
      zero_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        a_reg     <= ina;
        b_reg     <= inb;
        op_reg    <= op;
        acc_reg   <= '0;
        carry_reg <= (op == OP_SUB);
        count_reg <= '0;
      end else if (step) begin
        a_reg     <= a_reg >> DIGIT;
        b_reg     <= b_reg >> DIGIT;
        acc_reg   <= acc_next;
        carry_reg <= cy[DIGIT];
        count_reg <= last ? '0 : count_reg + CW'(1);
        if (last) begin
          out_reg  <= {final_msb, acc_next};
          zero_reg <= (acc_next == '0);
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign out   = out_reg;
  assign count = count_reg;
  assign busy  = (state_reg == RUN);
  assign done  = done_reg;
  assign zero  = zero_reg;

endmodule

// File: tb/tb_alu_serial.sv
// Bench for alu_serial: three configurations (16/1, 16/4, 32/8), vector table plus scoreboard
// for the bit-serial instance and hand-written sequences for the multi-cycle corner cases.
module tb_alu_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic        on1, busy1, done1, zero1;
  logic [15:0] ina1, inb1;
  logic [2:0]  op1;
  logic [16:0] out1;
  logic [3:0]  count1;

  logic        on2, busy2, done2, zero2;
  logic [15:0] ina2, inb2;
  logic [2:0]  op2;
  logic [16:0] out2;
  logic [1:0]  count2;

  logic        on3, busy3, done3, zero3;
  logic [31:0] ina3, inb3;
  logic [2:0]  op3;
  logic [32:0] out3;
  logic [1:0]  count3;

  alu_serial #(.WIDTH(16), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .on(on1), .ina(ina1), .inb(inb1), .op(op1),
    .out(out1), .count(count1), .busy(busy1), .done(done1), .zero(zero1)
  );

  alu_serial #(.WIDTH(16), .DIGIT(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .on(on2), .ina(ina2), .inb(inb2), .op(op2),
    .out(out2), .count(count2), .busy(busy2), .done(done2), .zero(zero2)
  );

  alu_serial #(.WIDTH(32), .DIGIT(8)) dut3 (
    .clk(clk), .rst_n(rst_n), .on(on3), .ina(ina3), .inb(inb3), .op(op3),
    .out(out3), .count(count3), .busy(busy3), .done(done3), .zero(zero3)
  );

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic [16:0] out;
    logic        zero;
  } exp_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [2:0]  op;
    logic [16:0] out;
    logic        zero;
  } vec_t;

  exp_t        sb[$];
  vec_t        vecs[14];
  logic [16:0] last_out;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                        input logic [2:0] o);
    case (o)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~(a & b)};
      3'd6:    return {1'b0, ~(a | b)};
      default: return {1'b0, ~(a ^ b)};
    endcase
  endfunction

  // Scoreboard for the bit-serial instance: every done pops one expectation.
  always @(negedge clk) begin
    if (rst_n && done1) begin
      exp_t e;
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check("out1", 64'(out1), 64'(e.out));
        check("zero1", 64'(zero1), 64'(e.zero));
        $display("txn out=%05h zero=%0d", out1, zero1);
      end
    end
  end

  task automatic start1(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o);
    @(posedge clk); #1;
    ina1 = a; inb1 = b; op1 = o; on1 = 1'b1;
    @(posedge clk); #1;
    on1 = 1'b0;
  endtask

  task automatic wait_done1();
    bit got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (done1) got = 1'b1;
    end
    check("done1_seen", 64'(got), 64'(1));
  endtask

  task automatic run1(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                      input logic [16:0] eo, input logic ez);
    sb.push_back('{eo, ez});
    start1(a, b, o);
    wait_done1();
    last_out = eo;
  endtask

  initial begin
    rst_n = 1'b0;
    on1 = 0; ina1 = 0; inb1 = 0; op1 = 0;
    on2 = 0; ina2 = 0; inb2 = 0; op2 = 0;
    on3 = 0; ina3 = 0; inb3 = 0; op3 = 0;
    last_out = '0;

    vecs[0]  = '{16'h0003, 16'h0005, 3'd1, 17'h1FFFE, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0003, 3'd1, 17'h00002, 1'b0};
    vecs[2]  = '{16'hA5A5, 16'hA5A5, 3'd4, 17'h00000, 1'b1};
    vecs[3]  = '{16'hA5A5, 16'hA5A5, 3'd5, 17'h05A5A, 1'b0};
    vecs[4]  = '{16'hA5A5, 16'hA5A5, 3'd3, 17'h0A5A5, 1'b0};
    vecs[5]  = '{16'hFFFF, 16'h0001, 3'd0, 17'h10000, 1'b1};
    vecs[6]  = '{16'h1234, 16'h1234, 3'd1, 17'h00000, 1'b1};
    vecs[7]  = '{16'hF0F0, 16'h0FF0, 3'd2, 17'h000F0, 1'b0};
    vecs[8]  = '{16'h0000, 16'h0000, 3'd6, 17'h0FFFF, 1'b0};
    vecs[9]  = '{16'h1234, 16'h1234, 3'd7, 17'h0FFFF, 1'b0};
    vecs[10] = '{16'h0000, 16'h0001, 3'd1, 17'h1FFFF, 1'b0};
    vecs[11] = '{16'hFFFF, 16'h0000, 3'd2, 17'h00000, 1'b1};
    vecs[12] = '{16'h00FF, 16'h0F0F, 3'd4, 17'h00FF0, 1'b0};
    vecs[13] = '{16'h8000, 16'h8000, 3'd0, 17'h10000, 1'b1};

    #12;
    check("rst_out1", 64'(out1), 64'(0));
    check("rst_busy1", 64'(busy1), 64'(0));
    check("rst_done1", 64'(done1), 64'(0));
    check("rst_count1", 64'(count1), 64'(0));
    check("rst_zero1", 64'(zero1), 64'(0));
    check("rst_out2", 64'(out2), 64'(0));
    check("rst_out3", 64'(out3), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Bit-serial ADD: busy/count walk and completion pulse.
    sb.push_back('{17'h13006, 1'b0});
    start1(16'h7003, 16'hC003, 3'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      check("run_busy", 64'(busy1), 64'(1));
      check("run_count", 64'(count1), 64'(k));
      check("run_done_low", 64'(done1), 64'(0));
      if (k == 8) check("run_out_hold", 64'(out1), 64'(0));
    end
    @(negedge clk);
    check("end_done", 64'(done1), 64'(1));
    check("end_busy", 64'(busy1), 64'(0));
    check("end_count", 64'(count1), 64'(0));
    @(negedge clk);
    check("done_one_cycle", 64'(done1), 64'(0));
    last_out = 17'h13006;

    // DIGIT=4: a second start during RUN is ignored.
    begin
      int dones = 0;
      int first = 0;
      @(posedge clk); #1;
      ina2 = 16'hFFFF; inb2 = 16'h0001; op2 = 3'd0; on2 = 1'b1;
      @(posedge clk); #1;
      on2 = 1'b0;
      for (int n = 1; n <= 12; n++) begin
        @(posedge clk); #1;
        if (n == 1) on2 = 1'b1;
        if (n == 2) on2 = 1'b0;
        if (done2) begin
          dones++;
          if (first == 0) first = n;
        end
      end
      check("d4_done_edge", 64'(first), 64'(4));
      check("d4_done_count", 64'(dones), 64'(1));
      check("d4_out", 64'(out2), 64'(17'h10000));
      check("d4_zero", 64'(zero2), 64'(1));
      check("d4_busy", 64'(busy2), 64'(0));
      $display("txn d4 out=%05h dones=%0d", out2, dones);
    end

    // 32/8 with start held high: one result every STEPS+1 cycles.
    begin
      int prev = 0;
      int nd = 0;
      @(posedge clk); #1;
      ina3 = 32'h12345678; inb3 = 32'h0FEDCBA9; op3 = 3'd0; on3 = 1'b1;
      @(posedge clk); #1;
      for (int n = 1; n <= 30; n++) begin
        @(posedge clk); #1;
        if (done3) begin
          check("held_out", 64'(out3), 64'(33'h022222221));
          if (nd > 0) check("held_period", 64'(n - prev), 64'(5));
          $display("txn held out=%09h edge=%0d", out3, n);
          prev = n;
          nd++;
        end
      end
      on3 = 1'b0;
      check("held_dones", 64'(nd), 64'(6));
      repeat (8) @(posedge clk);
      #1;
      check("held_idle", 64'(busy3), 64'(0));
    end

    for (int i = 0; i < 14; i++) begin
      run1(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].out, vecs[i].zero);
    end

    // Reset during the 8th RUN cycle aborts the operation.
    start1(16'h4321, 16'h1111, 3'd0);
    repeat (7) @(posedge clk);
    #2;
    check("abort_hold_out", 64'(out1), 64'(last_out));
    check("abort_count", 64'(count1), 64'(7));
    rst_n = 1'b0;
    #1;
    check("abort_out", 64'(out1), 64'(0));
    check("abort_busy", 64'(busy1), 64'(0));
    check("abort_count0", 64'(count1), 64'(0));
    check("abort_done", 64'(done1), 64'(0));
    check("abort_zero", 64'(zero1), 64'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_rst_out", 64'(out1), 64'(0));
    run1(16'h4321, 16'h1111, 3'd0, 17'h05432, 1'b0);

    for (int i = 0; i < 8; i++) begin
      logic [15:0] a, b;
      logic [2:0]  o;
      logic [16:0] e;
      a = 16'($urandom);
      b = 16'($urandom);
      o = 3'($urandom_range(7, 0));
      e = model(a, b, o);
      run1(a, b, o, e, (e[15:0] == 16'h0000));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
